// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared constants and types for the MEM pipeline stage.
// MEMControl bit indices, Size encodings and the wait-state FSM type.
package mem_stage_pkg;
  localparam int MEM_READ_BIT  = 1;
  localparam int MEM_WRITE_BIT = 0;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;
endpackage

// File: rtl/mem_stage_pipe_data_ram.sv
// data_ram: DEPTH_WORDS x 32 storage, byte-enabled synchronous write.
// Ports: i_clk, i_we, i_be[3:0], i_addr, i_wdata -> o_rdata (async read).
module data_ram #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);
  logic [31:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) begin
          r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/mem_stage_pipe.sv
// mem_stage_pipe: MEM stage with sub-word access, wait states, MEM/WB reg.
// In: EX/MEM bundle (address, data, ctrl, size). Out: stall, MEM/WB bundle.
module mem_stage_pipe
  import mem_stage_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WB_W        = 2,
  parameter int MEM_LATENCY = 0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [DATA_W-1:0] i_address,
  input  logic [DATA_W-1:0] i_data,
  input  logic [WB_W-1:0]   i_wb_control,
  input  logic [1:0]        i_mem_control,
  input  logic [1:0]        i_size,
  input  logic              i_sign_ext,
  input  logic              i_in_valid,
  output logic              o_stall,
  output logic [DATA_W-1:0] o_address,
  output logic [DATA_W-1:0] o_data,
  output logic [WB_W-1:0]   o_wb_control,
  output logic              o_out_valid,
  output logic              o_misaligned
);
  localparam int AW = $clog2(DEPTH_WORDS);

  logic          w_rd, w_wr, w_req, w_mis, w_acc;
  logic          w_half, w_byte, w_word;
  logic          w_stall, w_done, w_we;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata, w_rdata, w_load;
  logic [7:0]    w_lane8;
  logic [15:0]   w_lane16;
  logic [AW-1:0] w_idx;
  logic          w_unused;

  assign w_idx    = i_address[2 +: AW];
  assign w_unused = &{1'b0, i_address[DATA_W-1:AW+2]};

  // 2'b11 collapses to a plain read
  assign w_rd  = i_mem_control[MEM_READ_BIT];
  assign w_wr  = i_mem_control[MEM_WRITE_BIT] & ~w_rd;
  assign w_req = i_in_valid & (w_rd | w_wr);

  assign w_half = (i_size == SZ_HALF);
  assign w_byte = (i_size == SZ_BYTE);
  assign w_word = ~w_half & ~w_byte;

  assign w_mis = w_req & ((w_word & (i_address[1:0] != 2'b00))
                        | (w_half & i_address[0]));
  assign w_acc = w_req & ~w_mis;

  always_comb begin
    w_be     = 4'b1111;
    w_wdata  = i_data;
    w_lane16 = i_address[1] ? w_rdata[31:16] : w_rdata[15:0];
    w_lane8  = w_rdata[7:0];
    unique case (i_address[1:0])
      2'd1:    w_lane8 = w_rdata[15:8];
      2'd2:    w_lane8 = w_rdata[23:16];
      2'd3:    w_lane8 = w_rdata[31:24];
      default: w_lane8 = w_rdata[7:0];
    endcase
    w_load = w_rdata;
    unique case (1'b1)
      w_half: begin
        w_be    = i_address[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{i_data[15:0]}};
        w_load  = {{16{i_sign_ext & w_lane16[15]}}, w_lane16};
      end
      w_byte: begin
        w_be    = 4'b0001 << i_address[1:0];
        w_wdata = {4{i_data[7:0]}};
        w_load  = {{24{i_sign_ext & w_lane8[7]}}, w_lane8};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = i_data;
        w_load  = w_rdata;
      end
    endcase
  end

  generate
    if (MEM_LATENCY == 0) begin : g_nolat
      assign w_stall = 1'b0;
      assign w_done  = w_acc;
    end else begin : g_lat
      localparam int CW = $clog2(MEM_LATENCY + 1);
      localparam logic [CW-1:0] LAST = CW'(MEM_LATENCY);
      state_t        r_state;
      logic [CW-1:0] r_cnt;
      logic          w_last;

      assign w_last  = (r_state == ST_WAIT) && (r_cnt == LAST);
      assign w_stall = ~i_reset & w_acc & ~w_last;
      assign w_done  = w_acc & w_last;

      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end else begin
          unique case (r_state)
            ST_IDLE: begin
              if (w_acc) begin
                r_state <= ST_WAIT;
                r_cnt   <= CW'(1);
              end
            end
            ST_WAIT: begin
              if (r_cnt == LAST) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
            default: begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
            end
          endcase
        end
      end
    end
  endgenerate

  // reset aborts any in-flight store
  assign w_we    = ~i_reset & w_done & w_wr;
  assign o_stall = w_stall;

  data_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .i_clk  (i_clk),
    .i_we   (w_we),
    .i_be   (w_be),
    .i_addr (w_idx),
    .i_wdata(w_wdata),
    .o_rdata(w_rdata)
  );

  logic [DATA_W-1:0] r_address, r_data;
  logic [WB_W-1:0]   r_wb;
  logic              r_valid, r_mis;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_address <= '0;
      r_data    <= '0;
      r_wb      <= '0;
      r_valid   <= 1'b0;
      r_mis     <= 1'b0;
    end else begin
      r_address <= i_address;
      if (w_stall) begin
        r_data  <= '0;
        r_wb    <= '0;
        r_valid <= 1'b0;
        r_mis   <= 1'b0;
      end else if (w_mis) begin
        r_data  <= '0;
        r_wb    <= '0;
        r_valid <= 1'b1;
        r_mis   <= 1'b1;
      end else begin
        r_data  <= (w_acc & w_rd) ? w_load : '0;
        r_wb    <= i_in_valid ? i_wb_control : '0;
        r_valid <= i_in_valid;
        r_mis   <= 1'b0;
      end
    end
  end

  assign o_address    = r_address;
  assign o_data       = r_data;
  assign o_wb_control = r_wb;
  assign o_out_valid  = r_valid;
  assign o_misaligned = r_mis;
endmodule

// File: tb/tb_mem_stage_pipe.sv
// tb_mem_stage_pipe: directed checks of mem_stage_pipe at L=0, 2 and 3.
// Table-driven single-cycle vectors plus hand sequences for wait states.
module tb_mem_stage_pipe;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  wb;
    logic [1:0]  mc;
    logic [1:0]  sz;
    logic        se;
    logic        v;
  } in_t;

  typedef struct {
    in_t         i;
    logic [31:0] ed;
    logic [1:0]  ewb;
    logic        ev;
    logic        em;
  } vec_t;

  logic        clk;
  logic        rst    [3];
  in_t         x      [3];
  logic        o_stall[3];
  logic [31:0] o_addr [3];
  logic [31:0] o_data [3];
  logic [1:0]  o_wb   [3];
  logic        o_valid[3];
  logic        o_mis  [3];

  int checks = 0;
  int fails  = 0;
  vec_t tab[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_stage_pipe #(.DATA_W(32), .DEPTH_WORDS(256), .WB_W(2),
                   .MEM_LATENCY(0)) u_l0 (
    .i_clk(clk), .i_reset(rst[0]), .i_address(x[0].addr),
    .i_data(x[0].data), .i_wb_control(x[0].wb),
    .i_mem_control(x[0].mc), .i_size(x[0].sz),
    .i_sign_ext(x[0].se), .i_in_valid(x[0].v),
    .o_stall(o_stall[0]), .o_address(o_addr[0]),
    .o_data(o_data[0]), .o_wb_control(o_wb[0]),
    .o_out_valid(o_valid[0]), .o_misaligned(o_mis[0]));

  mem_stage_pipe #(.DATA_W(32), .DEPTH_WORDS(256), .WB_W(2),
                   .MEM_LATENCY(2)) u_l2 (
    .i_clk(clk), .i_reset(rst[1]), .i_address(x[1].addr),
    .i_data(x[1].data), .i_wb_control(x[1].wb),
    .i_mem_control(x[1].mc), .i_size(x[1].sz),
    .i_sign_ext(x[1].se), .i_in_valid(x[1].v),
    .o_stall(o_stall[1]), .o_address(o_addr[1]),
    .o_data(o_data[1]), .o_wb_control(o_wb[1]),
    .o_out_valid(o_valid[1]), .o_misaligned(o_mis[1]));

  mem_stage_pipe #(.DATA_W(32), .DEPTH_WORDS(256), .WB_W(2),
                   .MEM_LATENCY(3)) u_l3 (
    .i_clk(clk), .i_reset(rst[2]), .i_address(x[2].addr),
    .i_data(x[2].data), .i_wb_control(x[2].wb),
    .i_mem_control(x[2].mc), .i_size(x[2].sz),
    .i_sign_ext(x[2].se), .i_in_valid(x[2].v),
    .o_stall(o_stall[2]), .o_address(o_addr[2]),
    .o_data(o_data[2]), .o_wb_control(o_wb[2]),
    .o_out_valid(o_valid[2]), .o_misaligned(o_mis[2]));

  function automatic in_t mk(logic [31:0] a, logic [31:0] d,
                             logic [1:0] mc, logic [1:0] sz,
                             logic se, logic [1:0] wb, logic v);
    in_t r;
    r.addr = a; r.data = d; r.mc = mc; r.sz = sz;
    r.se = se; r.wb = wb; r.v = v;
    return r;
  endfunction

  task automatic add(in_t i, logic [31:0] ed, logic [1:0] ewb,
                     logic ev, logic em);
    vec_t t;
    t.i = i; t.ed = ed; t.ewb = ewb; t.ev = ev; t.em = em;
    tab.push_back(t);
  endtask

  task automatic chk(string nm, int idx, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d] got=%h exp=%h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_out(int d, string tag, logic [31:0] ea,
                         logic [31:0] ed, logic [1:0] ewb,
                         logic ev, logic em);
    chk({tag, "_addr"},  d, o_addr[d],  ea);
    chk({tag, "_data"},  d, o_data[d],  ed);
    chk({tag, "_wb"},    d, {30'd0, o_wb[d]}, {30'd0, ewb});
    chk({tag, "_valid"}, d, {31'd0, o_valid[d]}, {31'd0, ev});
    chk({tag, "_mis"},   d, {31'd0, o_mis[d]},   {31'd0, em});
  endtask

  // present v to DUT d; expect nstall stall cycles then the result
  task automatic lat(int d, in_t v, int nstall, logic [31:0] ed,
                     logic [1:0] ewb, logic em);
    x[d] = v;
    for (int k = 0; k < nstall; k++) begin
      #1;
      chk("stall_hi", d, {31'd0, o_stall[d]}, 32'd1);
      @(posedge clk); #1;
      chk("bub_valid", d, {31'd0, o_valid[d]}, 32'd0);
      chk("bub_wb", d, {30'd0, o_wb[d]}, 32'd0);
    end
    #1;
    chk("stall_lo", d, {31'd0, o_stall[d]}, 32'd0);
    @(posedge clk); #1;
    chk_out(d, "lat", v.addr, ed, ewb, 1'b1, em);
  endtask

  localparam logic [1:0] RD = 2'b10, WR = 2'b01, NOP = 2'b00;
  localparam logic [1:0] W = 2'b00, H = 2'b01, B = 2'b10;

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1;
      x[d]   = '0;
    end

    add(mk(32'h0, 32'hDEADBEEF, WR, W, 0, 2'b01, 1), 0, 2'b01, 1, 0);
    add(mk(32'h2, 32'h8, WR, W, 0, 2'b11, 1), 0, 2'b00, 1, 1);
    add(mk(32'h0, 32'h0, RD, W, 0, 2'b10, 1), 32'hDEADBEEF, 2'b10, 1, 0);
    add(mk(32'h8, 32'h8, WR, W, 0, 2'b01, 1), 0, 2'b01, 1, 0);
    add(mk(32'h8, 32'h0, RD, W, 0, 2'b11, 1), 32'h8, 2'b11, 1, 0);
    add(mk(32'h10, 32'h80FF7F01, WR, W, 0, 2'b01, 1), 0, 2'b01, 1, 0);
    add(mk(32'h13, 32'h0, RD, B, 1, 2'b10, 1), 32'hFFFFFF80, 2'b10, 1, 0);
    add(mk(32'h12, 32'h0, RD, H, 0, 2'b10, 1), 32'h000080FF, 2'b10, 1, 0);
    add(mk(32'h10, 32'h0, RD, B, 1, 2'b10, 1), 32'h00000001, 2'b10, 1, 0);
    add(mk(32'h11, 32'h123456AB, WR, B, 0, 2'b01, 1), 0, 2'b01, 1, 0);
    add(mk(32'h10, 32'h0, RD, W, 0, 2'b10, 1), 32'h80FFAB01, 2'b10, 1, 0);
    add(mk(32'h11, 32'h0, RD, H, 0, 2'b11, 1), 0, 2'b00, 1, 1);
    add(mk(32'h400, 32'h12345678, WR, W, 0, 2'b01, 1), 0, 2'b01, 1, 0);
    add(mk(32'h0, 32'h0, RD, W, 0, 2'b10, 1), 32'h12345678, 2'b10, 1, 0);
    add(mk(32'h4, 32'h0, RD, W, 0, 2'b11, 0), 0, 2'b00, 0, 0);
    add(mk(32'h5, 32'h0, NOP, W, 0, 2'b11, 1), 0, 2'b11, 1, 0);
    add(mk(32'h10, 32'hFFFFFFFF, 2'b11, 2'b11, 0, 2'b01, 1),
        32'h80FFAB01, 2'b01, 1, 0);
    add(mk(32'h10, 32'h0, RD, W, 0, 2'b10, 1), 32'h80FFAB01, 2'b10, 1, 0);
    add(mk(32'h10, 32'h0, RD, H, 1, 2'b10, 1), 32'hFFFFAB01, 2'b10, 1, 0);

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk_out(d, "rst", 32'h0, 32'h0, 2'b00, 1'b0, 1'b0);
      chk("rst_stall", d, {31'd0, o_stall[d]}, 32'd0);
      rst[d] = 1'b0;
    end

    foreach (tab[i]) begin
      x[0] = tab[i].i;
      #1;
      chk("vec_stall", i, {31'd0, o_stall[0]}, 32'd0);
      @(posedge clk); #1;
      chk_out(0, "vec", tab[i].i.addr, tab[i].ed, tab[i].ewb,
              tab[i].ev, tab[i].em);
    end
    x[0] = '0;

    lat(1, mk(32'h20, 32'hCAFEF00D, WR, W, 0, 2'b01, 1), 2, 0, 2'b01, 0);
    lat(1, mk(32'h20, 32'h0, RD, W, 0, 2'b10, 1), 2,
        32'hCAFEF00D, 2'b10, 0);
    lat(1, mk(32'h22, 32'h0, RD, H, 0, 2'b11, 1), 2,
        32'h0000CAFE, 2'b11, 0);
    lat(1, mk(32'h21, 32'h0, RD, W, 0, 2'b11, 1), 0, 0, 2'b00, 1);
    lat(1, mk(32'h24, 32'h0, NOP, W, 0, 2'b11, 1), 0, 0, 2'b11, 0);
    x[1] = '0;

    lat(2, mk(32'h30, 32'h11111111, WR, W, 0, 2'b01, 1), 3, 0, 2'b01, 0);
    x[2] = mk(32'h30, 32'h22222222, WR, W, 0, 2'b01, 1);
    #1;
    chk("ab_stall1", 2, {31'd0, o_stall[2]}, 32'd1);
    @(posedge clk); #1;
    rst[2] = 1'b1;
    #1;
    chk("ab_rst_stall", 2, {31'd0, o_stall[2]}, 32'd0);
    @(posedge clk); #1;
    rst[2] = 1'b0;
    chk_out(2, "ab_rst", 32'h0, 32'h0, 2'b00, 1'b0, 1'b0);
    lat(2, mk(32'h30, 32'h0, RD, W, 0, 2'b10, 1), 3,
        32'h11111111, 2'b10, 0);
    x[2] = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/mem_stage_pipe.md
# mem_stage_pipe

Parametrised memory pipeline stage: accepts an EX/MEM bundle (ALU address, store data, WB controls, MEM controls), performs a data-memory access with byte/halfword/word granularity and configurable wait states, and registers the result into the MEM/WB pipeline register. It replaces the fixed 32-bit, word-only, single-cycle MEM stage. It adds a stall output for multi-cycle memory, misalignment detection, and sign/zero-extended sub-word loads.

## Interface
- DATA_W, 32: data and address width; must be 32.
- DEPTH_WORDS, 256: data RAM depth in 32-bit words; power of two.
- WB_W, 2: width of the WB control bundle passed through.
- MEM_LATENCY, 0: extra wait cycles per memory access; 0 = single-cycle.
- Clk  in  1  clock, all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Address  in  32  byte address (ALU result).
- Data  in  32  store data; byte/half taken from low bits.
- WBControl  in  WB_W  write-back controls, passed through.
- MEMControl  in  2  bit1 MemRead, bit0 MemWrite; 2'b11 is illegal, treated as read only.
- Size  in  2  00 word, 01 halfword, 10 byte, 11 treated as word.
- SignExt  in  1  loads: 1 sign-extend, 0 zero-extend.
- InValid  in  1  bundle is a real instruction (0 = bubble).
- Stall  out  1  combinational; upstream holds all inputs while high.
- AddressOut  out  32  registered Address.
- DataOut  out  32  registered load data (0 for non-loads).
- WBControlOut  out  WB_W  registered WB controls (0 on bubble or fault).
- OutValid  out  1  registered; MEM/WB slot holds a real instruction.
- Misaligned  out  1  registered; access faulted on alignment.

## Operation
- Word index = Address[2 +: log2(DEPTH_WORDS)]; higher address bits ignored (wrap-around). Little-endian byte lanes selected by Address[1:0].
- Misaligned when access requested (InValid & (MemRead|MemWrite)) and: word with Address[1:0]≠0, or half with Address[0]≠0. A misaligned access does not touch the RAM and never stalls. It is registered with Misaligned=1, WBControlOut=0, DataOut=0 and OutValid=1.
- Store: byte-enabled write of the selected lanes on the completing edge; other bytes unchanged.
- Load: extract the lane, then sign- or zero-extend to 32 bits per SignExt.
- FSM (only when MEM_LATENCY>0): IDLE, WAIT, with wait counter cnt.
  - IDLE → WAIT when an aligned access is presented; cnt=1.
  - WAIT: cnt increments each cycle. When cnt==MEM_LATENCY the access completes on that edge and the FSM returns to IDLE.
  - Stall = aligned access & ~(state==WAIT & cnt==MEM_LATENCY). It is forced 0 in Reset.
- While Stall is high, the output register loads a bubble: OutValid=0, WBControlOut=0, DataOut=0, Misaligned=0. AddressOut is still loaded.
- Non-memory valid instruction: passes through in one cycle with DataOut=0.
- Reset mid-WAIT aborts the access. No RAM write occurs, the FSM goes to IDLE and cnt=0.
- RAM contents are not affected by Reset.

## Timing
- Reset values: AddressOut=0, DataOut=0, WBControlOut=0, OutValid=0, Misaligned=0, FSM IDLE, cnt=0.
- MEM_LATENCY=0: all results appear on outputs 1 cycle after presentation; Stall is constantly 0.
- MEM_LATENCY=L: Stall is high for L cycles starting in the presentation cycle. The result is registered at the edge ending cycle L+1.
- RAM: synchronous write, asynchronous read. A load completing on the edge after a store to the same word sees the stored data.
- Back-to-back accesses: the next access may start in the cycle immediately after completion (IDLE re-entry with a new request goes straight to WAIT).

## Structure
- Package mem_stage_pkg holds:
  - MEMControl bit indices (MEM_READ_BIT=1, MEM_WRITE_BIT=0);
  - Size encodings (SZ_WORD, SZ_HALF, SZ_BYTE);
  - FSM state typedef.
- Sub-module data_ram contains DEPTH_WORDS×32 storage with a 4-bit byte enable, synchronous write and asynchronous read.
- Top level contains the alignment check, lane steering/extension, FSM/counter and MEM/WB register.

## Test plan
- Word store/load, L=0:
  - Cycle 0: write 0x00000008 to address 2 with word size → Misaligned=1, WBControlOut=0, RAM unchanged.
  - Then write 0x00000008 to address 8 and read address 8 → DataOut=0x00000008 one cycle after the read.
- Sub-word load:
  - Store word 0x80FF7F01 at address 0x10.
  - Byte load at 0x13 with SignExt=1 → 0xFFFFFF80.
  - Halfword load at 0x12 with SignExt=0 → 0x000080FF.
  - Byte load at 0x10 → 0x00000001.
- Byte store merge: after the above, byte-store 0xAB at address 0x11 → word load at 0x10 returns 0x80FFAB01.
- Wait states, L=2:
  - Word load presented at t0 → Stall high for exactly 2 cycles; OutValid=0 for those 2 cycles.
  - Data is registered at the 3rd edge. A second load presented immediately after also stalls for 2 cycles.
- Reset mid-WAIT, L=3: a store is presented and Reset is asserted in the 2nd stall cycle → subsequent load of that address returns the old value; outputs are 0 the cycle after Reset.
- Wrap-around, DEPTH_WORDS=256: store 0x12345678 to address 0x400, then load address 0x0 → 0x12345678.
